uart_fifo_core: RTL

//  Single-clock parametrised UART: TX and RX serialisers with shared baud-tick

---
 rtl/uart_fifo_core.sv | 333 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_core.sv
// UART with shared baud divider, oversampled RX, TX/RX FIFOs, error flags.
// Optional parity bit in both directions when UART_PARITY_EN is defined.
module uart_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr,
   input  logic [W-1:0] din,
   input  logic         rd,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   cnt;
   logic          do_wr;
   logic          do_rd;

   assign empty = (cnt == '0);
   assign full  = (cnt == FULL_CNT);
   assign do_rd = rd && !empty;
   // a full FIFO still accepts a write when the head leaves the same cycle
   assign do_wr = wr && (!full || do_rd);
   assign dout  = mem[rp];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wp] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_wr) wp <= wp + AW'(1);
         if (do_rd) rp <= rp + AW'(1);
         unique case ({do_wr, do_rd})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

module uart_fifo_core #(
   parameter int DATA_W     = 8,
   parameter int OSR        = 16,
   parameter int CLK_DIV    = 27,
   parameter int FIFO_DEPTH = 4,
   parameter int STOP_BITS  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tx_wr,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_full,
   output logic              tx_out,
   output logic              tx_busy,
   input  logic              rx_in,
   input  logic              rx_rd,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_empty,
   output logic              rx_frame_err,
   output logic              rx_overrun,
`ifdef UART_PARITY_EN
   input  logic              parity_odd,
   output logic              rx_parity_err,
`endif
   input  logic              err_clr
);
   localparam int TW = $clog2(OSR);
   localparam int BW = $clog2(DATA_W);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [TW-1:0] T_LAST   = TW'(OSR - 1);
   localparam logic [TW-1:0] T_HALF   = TW'(OSR / 2 - 1);
   localparam logic [BW-1:0] D_LAST   = BW'(DATA_W - 1);
   localparam logic [BW-1:0] S_LAST   = BW'(STOP_BITS - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PAR,
      ST_STOP
   } st_t;

   logic [DW-1:0] div_cnt;
   logic          tick;

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) div_cnt <= '0;
      else       div_cnt <= tick ? '0 : div_cnt + DW'(1);
   end

   logic [DATA_W-1:0] tx_head;
   logic              tx_empty;
   logic              tx_pop;
   st_t               tx_st;
   logic [TW-1:0]     tx_tc;
   logic [BW-1:0]     tx_bc;
   logic [DATA_W-1:0] tx_sh;
   logic              tx_end;
`ifdef UART_PARITY_EN
   logic              tx_par;
`endif

   uart_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (tx_wr),
      .din   (tx_data),
      .rd    (tx_pop),
      .dout  (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   assign tx_end  = (tx_tc == T_LAST);
   assign tx_busy = (tx_st != ST_IDLE) || !tx_empty;
   // load from IDLE, or straight out of the last stop bit for back-to-back
   assign tx_pop  = tick && !tx_empty &&
                    ((tx_st == ST_IDLE) ||
                     (tx_st == ST_STOP && tx_end && tx_bc == S_LAST));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_st  <= ST_IDLE;
         tx_out <= 1'b1;
         tx_tc  <= '0;
         tx_bc  <= '0;
         tx_sh  <= '0;
`ifdef UART_PARITY_EN
         tx_par <= 1'b0;
`endif
      end else if (tick) begin
         if (tx_st != ST_IDLE) tx_tc <= tx_end ? '0 : tx_tc + TW'(1);
         unique case (tx_st)
            ST_IDLE: begin
               if (tx_pop) tx_st <= ST_START;
            end
            ST_START: begin
               if (tx_end) begin
                  tx_st  <= ST_DATA;
                  tx_out <= tx_sh[0];
                  tx_bc  <= '0;
               end
            end
            ST_DATA: begin
               if (tx_end) begin
                  if (tx_bc == D_LAST) begin
`ifdef UART_PARITY_EN
                     tx_st  <= ST_PAR;
                     tx_out <= tx_par;
`else
                     tx_st  <= ST_STOP;
                     tx_out <= 1'b1;
`endif
                     tx_bc  <= '0;
                  end else begin
                     tx_sh  <= tx_sh >> 1;
                     tx_out <= tx_sh[1];
                     tx_bc  <= tx_bc + BW'(1);
                  end
               end
            end
            ST_PAR: begin
               if (tx_end) begin
                  tx_st  <= ST_STOP;
                  tx_out <= 1'b1;
               end
            end
            ST_STOP: begin
               if (tx_end) begin
                  if (tx_bc == S_LAST)
                     tx_st <= tx_pop ? ST_START : ST_IDLE;
                  else
                     tx_bc <= tx_bc + BW'(1);
               end
            end
            default: tx_st <= ST_IDLE;
         endcase
         if (tx_pop) begin
            tx_sh  <= tx_head;
            tx_out <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par <= (^tx_head) ^ parity_odd;
`endif
         end
      end
   end

   logic              rx_s1;
   logic              rx_s2;
   st_t               rx_st;
   logic [TW-1:0]     rx_tc;
   logic [BW-1:0]     rx_bc;
   logic [DATA_W-1:0] rx_sh;
   logic              rx_end;
   logic              rx_stop_smp;
   logic              rx_push;
   logic              rx_full;
   logic [DATA_W-1:0] rx_head;
   logic              set_fe;
   logic              set_ovr;
`ifdef UART_PARITY_EN
   logic              set_pe;
`endif

   assign rx_end      = (rx_tc == T_LAST);
   assign rx_stop_smp = tick && (rx_st == ST_STOP) && rx_end;
   assign rx_push     = rx_stop_smp && rx_s2;
   assign set_fe      = rx_stop_smp && !rx_s2;
   assign set_ovr     = rx_push && rx_full && !rx_rd;
`ifdef UART_PARITY_EN
   assign set_pe      = tick && (rx_st == ST_PAR) && rx_end &&
                        (rx_s2 != ((^rx_sh) ^ parity_odd));
`endif

   uart_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .wr    (rx_push),
      .din   (rx_sh),
      .rd    (rx_rd),
      .dout  (rx_head),
      .full  (rx_full),
      .empty (rx_empty)
   );

   assign rx_data = rx_empty ? '0 : rx_head;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_st <= ST_IDLE;
         rx_tc <= '0;
         rx_bc <= '0;
         rx_sh <= '0;
      end else begin
         rx_s1 <= rx_in;
         rx_s2 <= rx_s1;
         if (tick) begin
            unique case (rx_st)
               ST_IDLE: begin
                  if (!rx_s2) begin
                     rx_st <= ST_START;
                     rx_tc <= '0;
                  end
               end
               ST_START: begin
                  if (rx_tc == T_HALF) begin
                     rx_tc <= '0;
                     rx_bc <= '0;
                     rx_st <= rx_s2 ? ST_IDLE : ST_DATA;
                  end else begin
                     rx_tc <= rx_tc + TW'(1);
                  end
               end
               ST_DATA: begin
                  if (rx_end) begin
                     rx_tc <= '0;
                     rx_sh <= {rx_s2, rx_sh[DATA_W-1:1]};
                     if (rx_bc == D_LAST)
`ifdef UART_PARITY_EN
                        rx_st <= ST_PAR;
`else
                        rx_st <= ST_STOP;
`endif
                     else
                        rx_bc <= rx_bc + BW'(1);
                  end else begin
                     rx_tc <= rx_tc + TW'(1);
                  end
               end
               ST_PAR: begin
                  if (rx_end) begin
                     rx_tc <= '0;
                     rx_st <= ST_STOP;
                  end else begin
                     rx_tc <= rx_tc + TW'(1);
                  end
               end
               ST_STOP: begin
                  // leave at mid stop bit so the next start edge is caught
                  if (rx_end) begin
                     rx_tc <= '0;
                     rx_st <= ST_IDLE;
                  end else begin
                     rx_tc <= rx_tc + TW'(1);
                  end
               end
               default: rx_st <= ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_frame_err  <= 1'b0;
         rx_overrun    <= 1'b0;
`ifdef UART_PARITY_EN
         rx_parity_err <= 1'b0;
`endif
      end else if (err_clr) begin
         rx_frame_err  <= 1'b0;
         rx_overrun    <= 1'b0;
`ifdef UART_PARITY_EN
         rx_parity_err <= 1'b0;
`endif
      end else begin
         if (set_fe)  rx_frame_err  <= 1'b1;
         if (set_ovr) rx_overrun    <= 1'b1;
`ifdef UART_PARITY_EN
         if (set_pe)  rx_parity_err <= 1'b1;
`endif
      end
   end
endmodule
